// File: rtl/pipeline_stall_ctrl.sv
// Purpose : stall/flush control for hazards that forwarding cannot resolve: load-use, taken branch, data-memory wait.
// Latency : stall/flush outputs are combinational (zero cycles); the watchdog flag is registered and sticky.
// Backpr. : a memory wait freezes IF..IM and bubbles WB until i_IM_mem_ready; a pending branch/load-use is held, not acted on.
//
// Ports:
//   i_clk, i_reset_n              core clock, asynchronous active-low reset
//   i_ID_src_reg_1/2, i_IE_dst_reg decode sources and execute destination, for load-use detection
//   i_ctrl_IE_mem_rd              execute-stage instruction is a load
//   i_IE_branch_taken             execute-stage branch/jump resolved taken
//   i_IM_mem_req, i_IM_mem_ready  memory-stage access handshake
//   o_*_stall / o_*_flush         per-stage hold and bubble controls
//   o_mem_timeout                 sticky watchdog: a wait reached MEM_TIMEOUT cycles
//   o_stall_cnt, o_flush_cnt      performance counters (PIPE_PERF_CNT_EN only, otherwise 0)
//
// Build option: define PIPE_PERF_CNT_EN to instantiate the saturating stall/flush counters.

module pipeline_stall_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [4:0]       i_ID_src_reg_1,
   input  logic [4:0]       i_ID_src_reg_2,
   input  logic [4:0]       i_IE_dst_reg,
   input  logic             i_ctrl_IE_mem_rd,
   input  logic             i_IE_branch_taken,
   input  logic             i_IM_mem_req,
   input  logic             i_IM_mem_ready,
   output logic             o_IF_stall,
   output logic             o_ID_stall,
   output logic             o_ID_flush,
   output logic             o_IE_flush,
   output logic             o_IE_stall,
   output logic             o_IM_stall,
   output logic             o_WB_flush,
   output logic             o_mem_timeout,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   // Timeout values below 1 are treated as 1 so the counter never has zero width.
   localparam int TMO_MAX = (MEM_TIMEOUT < 1) ? 1 : MEM_TIMEOUT;
   localparam int TMO_W   = $clog2(TMO_MAX + 1);

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic [TMO_W-1:0] tmo_cnt_d;
   logic             tmo_q;

   logic mem_wait;
   logic load_use;
   logic branch;

   // ---------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------
   assign mem_wait = i_IM_mem_req & ~i_IM_mem_ready;
   assign branch   = i_IE_branch_taken;
   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = i_ctrl_IE_mem_rd & (i_IE_dst_reg != 5'd0) &
                     ((i_IE_dst_reg == i_ID_src_reg_1) | (i_IE_dst_reg == i_ID_src_reg_2));

   // ---------------------------------------------------------------
   // Stall/flush outputs, priority mem_wait > branch > load_use.
   // Gated by i_reset_n so every control drops asynchronously in reset.
   // ---------------------------------------------------------------
   always_comb begin
      o_IF_stall = 1'b0;
      o_ID_stall = 1'b0;
      o_IE_stall = 1'b0;
      o_IM_stall = 1'b0;
      o_ID_flush = 1'b0;
      o_IE_flush = 1'b0;
      o_WB_flush = 1'b0;
      if (i_reset_n) begin
         if (mem_wait) begin
            // Freeze everything up to IM; a branch/load-use stays in place and
            // is re-evaluated once the access completes.
            o_IF_stall = 1'b1;
            o_ID_stall = 1'b1;
            o_IE_stall = 1'b1;
            o_IM_stall = 1'b1;
            o_WB_flush = 1'b1;
         end else if (branch) begin
            o_ID_flush = 1'b1;
            o_IE_flush = 1'b1;
         end else if (load_use) begin
            // One cycle only: the load moves on to IM and the match clears.
            o_IF_stall = 1'b1;
            o_ID_stall = 1'b1;
            o_IE_flush = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Wait FSM and watchdog counter.
   // The counter tracks the number of consecutive waiting cycles: it is
   // incremented on every edge that ends a waiting cycle (the state we are
   // heading into is MEM_WAIT), so after the N-th waiting cycle it holds N.
   // ---------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = tmo_cnt_q;
      case (state_q)
         IDLE:     if (mem_wait)  state_d = MEM_WAIT;
         MEM_WAIT: if (!mem_wait) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      if (state_d == MEM_WAIT) begin
         if (tmo_cnt_q != TMO_W'(TMO_MAX))
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end else begin
         tmo_cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= IDLE;
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
         // Sticky until reset; the access itself keeps stalling normally.
         if (tmo_cnt_d == TMO_W'(TMO_MAX))
            tmo_q <= 1'b1;
      end
   end

   assign o_mem_timeout = tmo_q;

   // ---------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (o_IF_stall && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if ((o_ID_flush || o_IE_flush) && !(&flush_cnt_q))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Stall/flush side of the pipeline hazard handling. It is the complement of the forwarding path: it covers hazards that bypass cannot resolve.
- Detects load-use hazards between the decode and execute stages, taken branches resolved in execute, and multi-cycle data-memory waits in the memory stage.
- Drives per-stage stall (hold) and flush (bubble) controls to the pipeline registers. Tracks memory-wait duration with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles after which o_mem_timeout sets (minimum 1).
- CNT_W, 32, width of the optional performance counters.

Ports:
- i_clk  input  1  core clock
- i_reset_n  input  1  asynchronous active-low reset
- i_ID_src_reg_1  input  5  rs1 of instruction in decode
- i_ID_src_reg_2  input  5  rs2 of instruction in decode
- i_IE_dst_reg  input  5  rd of instruction in execute
- i_ctrl_IE_mem_rd  input  1  execute-stage instruction is a load
- i_IE_branch_taken  input  1  execute-stage branch/jump resolved taken
- i_IM_mem_req  input  1  memory stage has an active load/store
- i_IM_mem_ready  input  1  data memory completes the access this cycle
- o_IF_stall  output  1  hold PC / IF-ID register
- o_ID_stall  output  1  hold ID-IE register inputs (decode stage frozen)
- o_ID_flush  output  1  zero IF-ID register
- o_IE_flush  output  1  insert bubble into ID-IE register
- o_IE_stall  output  1  hold IE-IM register
- o_IM_stall  output  1  hold memory stage
- o_WB_flush  output  1  insert bubble into IM-WB register
- o_mem_timeout  output  1  sticky watchdog error
- o_stall_cnt  output  CNT_W  stall cycle count (optional feature only)
- o_flush_cnt  output  CNT_W  flush event count (optional feature only)

Behaviour:
- Reset is asynchronous on i_reset_n low. Effects:
  - FSM goes to IDLE; timeout counter goes to 0; o_mem_timeout goes to 0; perf counters go to 0.
  - All stall/flush outputs go to 0 while reset is asserted, regardless of inputs.
- Hazard conditions, evaluated combinationally each cycle (zero latency):
  - mem_wait = i_IM_mem_req & ~i_IM_mem_ready.
  - load_use = i_ctrl_IE_mem_rd & (i_IE_dst_reg != 0) & ((i_IE_dst_reg == i_ID_src_reg_1) | (i_IE_dst_reg == i_ID_src_reg_2)).
  - branch = i_IE_branch_taken.
- Priority: mem_wait > branch > load_use.
  - mem_wait: IF, ID, IE and IM stalls = 1; o_WB_flush = 1; ID/IE flush = 0. The branch or load-use is held, not acted on, and re-evaluates when the wait clears.
  - branch (no mem_wait): o_ID_flush = 1, o_IE_flush = 1; no stalls; load_use ignored that cycle.
  - load_use only: o_IF_stall = 1, o_ID_stall = 1, o_IE_flush = 1 for exactly one cycle, because the load then advances to IM and the condition clears.
- FSM has two states, IDLE and MEM_WAIT:
  - IDLE -> MEM_WAIT when mem_wait.
  - MEM_WAIT -> IDLE on the cycle after i_IM_mem_ready (or when i_IM_mem_req drops). The stall deasserts in the same cycle ready is seen.
  - Timeout counter increments each cycle in MEM_WAIT, saturates at MEM_TIMEOUT, and clears on return to IDLE.
  - o_mem_timeout sets when the counter reaches MEM_TIMEOUT and stays set until reset. The stall continues; the watchdog does not abort the access.
- Reset mid-wait: all outputs drop asynchronously and the FSM restarts in IDLE.
- A back-to-back memory request (ready then a new req with ~ready) re-enters MEM_WAIT with the counter restarted from 0.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - o_stall_cnt increments on every cycle where o_IF_stall = 1.
  - o_flush_cnt increments on every cycle where o_ID_flush | o_IE_flush = 1.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter registers are instantiated.

Test Plan:
- Load-use: IE load rd=5, ID rs2=5, no mem req -> o_IF_stall=o_ID_stall=o_IE_flush=1 for one cycle; with rd=0 -> all 0.
- Taken branch: i_IE_branch_taken=1 with load_use also true -> o_ID_flush=o_IE_flush=1, o_IF_stall=0.
- Mem wait: req=1, ready=0 for 3 cycles then 1 -> IF/ID/IE/IM stall=1 and o_WB_flush=1 for 3 cycles, all 0 when ready; branch asserted throughout -> flush only after ready.
- Timeout: MEM_TIMEOUT=4, req=1, ready=0 for 6 cycles -> o_mem_timeout rises after 4th MEM_WAIT cycle, remains 1 after ready, clears only on i_reset_n=0.
- Reset mid-wait: drop i_reset_n during MEM_WAIT -> all outputs 0 immediately (asynchronously); after release with req=0 -> IDLE, no stall.
- PIPE_PERF_CNT_EN: 1 load-use + 3-cycle mem wait + 1 branch -> o_stall_cnt=4, o_flush_cnt=2; macro undefined -> both read 0.
